// File: rtl/uart_tx_fifo.sv
// Transmit FIFO sitting between the UART register interface and the transmitter.
// Show-ahead head entry, occupancy count, threshold interrupt and sticky overflow flag.
module uart_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  fifo_clr,
  input  logic                  tx_done,
  input  logic [ADDR_WIDTH-1:0] thr_level,
  input  logic                  ov_clr,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_empty_status,
  output logic                  tx_full,
  output logic [ADDR_WIDTH:0]   tx_count,
  output logic                  tx_thr_int,
  output logic                  ov_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   CNT_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   CNT_ZERO  = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_ZERO  = {ADDR_WIDTH{1'b0}};

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_r;
  logic [ADDR_WIDTH-1:0] rd_ptr_r;
  logic [ADDR_WIDTH:0]   count_r;
  logic                  ov_err_r;

  logic                  empty_s;
  logic                  full_s;
  logic                  wr_ok_s;
  logic                  rd_ok_s;
  logic                  ov_set_s;
  logic [ADDR_WIDTH:0]   count_nxt_s;

  assign empty_s  = (count_r == CNT_ZERO);
  assign full_s   = (count_r == CNT_DEPTH);
  assign wr_ok_s  = wr_en & ~full_s;
  assign rd_ok_s  = tx_done & ~empty_s;
  assign ov_set_s = wr_en & full_s;

  // Next occupancy from the accepted write/pop pair
  always_comb begin
    count_nxt_s = count_r;
    case ({wr_ok_s, rd_ok_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointer, count and overflow state; fifo_clr overrides any concurrent traffic
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
      ov_err_r <= 1'b0;
    end else if (fifo_clr) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
      ov_err_r <= 1'b0;
    end else begin
      if (wr_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (rd_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      count_r <= count_nxt_s;
      // Setting wins over a same-cycle clear so no overflow event is lost
      if (ov_set_s) begin
        ov_err_r <= 1'b1;
      end else if (ov_clr) begin
        ov_err_r <= 1'b0;
      end else begin
        ov_err_r <= ov_err_r;
      end
    end
  end

  // Storage array is deliberately left unreset; occupancy alone defines validity
  always_ff @(posedge clk) begin
    if (wr_ok_s && !fifo_clr) begin
      mem[wr_ptr_r] <= wr_data;
    end
  end

  assign tx_data         = empty_s ? {DATA_WIDTH{1'b0}} : mem[rd_ptr_r];
  assign tx_empty_status = empty_s;
  assign tx_full         = full_s;
  assign tx_count        = count_r;
  assign tx_thr_int      = (count_r <= {1'b0, thr_level});
  assign ov_err          = ov_err_r;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo.
// Each task drives one scenario and compares outputs against hand-computed values.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       fifo_clr;
  logic       tx_done;
  logic [3:0] thr_level;
  logic       ov_clr;
  logic [7:0] tx_data;
  logic       tx_empty_status;
  logic       tx_full;
  logic [4:0] tx_count;
  logic       tx_thr_int;
  logic       ov_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .fifo_clr(fifo_clr), .tx_done(tx_done), .thr_level(thr_level),
    .ov_clr(ov_clr), .tx_data(tx_data), .tx_empty_status(tx_empty_status),
    .tx_full(tx_full), .tx_count(tx_count), .tx_thr_int(tx_thr_int),
    .ov_err(ov_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    wr_en = 1'b1; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pop;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", tx_data); end
    checks++; if (tx_empty_status !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", tx_empty_status); end
    checks++; if (tx_full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", tx_full); end
    checks++; if (tx_count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", tx_count); end
    checks++; if (tx_thr_int !== 1'b1) begin errors++; $display("FAIL reset_thr got=%b exp=1", tx_thr_int); end
    checks++; if (ov_err !== 1'b0) begin errors++; $display("FAIL reset_ov got=%b exp=0", ov_err); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single;
    pop();
    checks++; if (tx_count !== 5'd0) begin errors++; $display("FAIL empty_pop_count got=%0d exp=0", tx_count); end
    checks++; if (ov_err !== 1'b0) begin errors++; $display("FAIL empty_pop_ov got=%b exp=0", ov_err); end
    push(8'hA5);
    checks++; if (tx_empty_status !== 1'b0) begin errors++; $display("FAIL single_empty got=%b exp=0", tx_empty_status); end
    checks++; if (tx_data !== 8'hA5) begin errors++; $display("FAIL single_data got=%h exp=a5", tx_data); end
    checks++; if (tx_count !== 5'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", tx_count); end
    pop();
    checks++; if (tx_empty_status !== 1'b1) begin errors++; $display("FAIL single_pop_empty got=%b exp=1", tx_empty_status); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL single_pop_data got=%h exp=00", tx_data); end
  endtask

  task automatic test_fill;
    for (int i = 0; i < 16; i++) push(8'(i));
    checks++; if (tx_full !== 1'b1) begin errors++; $display("FAIL fill_full got=%b exp=1", tx_full); end
    checks++; if (tx_count !== 5'd16) begin errors++; $display("FAIL fill_count got=%0d exp=16", tx_count); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL fill_head got=%h exp=00", tx_data); end
    checks++; if (tx_thr_int !== 1'b0) begin errors++; $display("FAIL fill_thr got=%b exp=0", tx_thr_int); end
    push(8'hFF);
    checks++; if (ov_err !== 1'b1) begin errors++; $display("FAIL overflow_ov got=%b exp=1", ov_err); end
    checks++; if (tx_count !== 5'd16) begin errors++; $display("FAIL overflow_count got=%0d exp=16", tx_count); end
    ov_clr = 1'b1; tick(); ov_clr = 1'b0;
    checks++; if (ov_err !== 1'b0) begin errors++; $display("FAIL ov_clr got=%b exp=0", ov_err); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (tx_data !== 8'(i)) begin errors++; $display("FAIL fill_order[%0d] got=%h exp=%h", i, tx_data, 8'(i)); end
      pop();
    end
    checks++; if (tx_empty_status !== 1'b1) begin errors++; $display("FAIL drain_empty got=%b exp=1", tx_empty_status); end
    checks++; if (tx_count !== 5'd0) begin errors++; $display("FAIL drain_count got=%0d exp=0", tx_count); end
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 10; i++) push(8'h30 + 8'(i));
    for (int i = 0; i < 10; i++) begin
      checks++; if (tx_data !== 8'h30 + 8'(i)) begin errors++; $display("FAIL wrap_a[%0d] got=%h exp=%h", i, tx_data, 8'h30 + 8'(i)); end
      pop();
    end
    for (int i = 0; i < 10; i++) push(8'h40 + 8'(i));
    checks++; if (tx_count !== 5'd10) begin errors++; $display("FAIL wrap_mid_count got=%0d exp=10", tx_count); end
    for (int i = 0; i < 10; i++) begin
      checks++; if (tx_data !== 8'h40 + 8'(i)) begin errors++; $display("FAIL wrap_b[%0d] got=%h exp=%h", i, tx_data, 8'h40 + 8'(i)); end
      pop();
    end
    checks++; if (tx_count !== 5'd0) begin errors++; $display("FAIL wrap_end_count got=%0d exp=0", tx_count); end
  endtask

  task automatic test_simultaneous;
    wr_en = 1'b1; wr_data = 8'h77; tx_done = 1'b1;
    tick();
    wr_en = 1'b0; tx_done = 1'b0;
    checks++; if (tx_count !== 5'd1) begin errors++; $display("FAIL simul_empty_count got=%0d exp=1", tx_count); end
    checks++; if (tx_data !== 8'h77) begin errors++; $display("FAIL simul_empty_head got=%h exp=77", tx_data); end
    for (int i = 1; i < 16; i++) push(8'h80 + 8'(i));
    wr_en = 1'b1; wr_data = 8'hEE; tx_done = 1'b1;
    tick();
    wr_en = 1'b0; tx_done = 1'b0;
    checks++; if (tx_count !== 5'd15) begin errors++; $display("FAIL simul_full_count got=%0d exp=15", tx_count); end
    checks++; if (ov_err !== 1'b1) begin errors++; $display("FAIL simul_full_ov got=%b exp=1", ov_err); end
    checks++; if (tx_data !== 8'h81) begin errors++; $display("FAIL simul_full_head got=%h exp=81", tx_data); end
    ov_clr = 1'b1; tick(); ov_clr = 1'b0;
    checks++; if (ov_err !== 1'b0) begin errors++; $display("FAIL simul_ov_clr got=%b exp=0", ov_err); end
    push(8'h90);
    ov_clr = 1'b1; wr_en = 1'b1; wr_data = 8'h55;
    tick();
    ov_clr = 1'b0; wr_en = 1'b0;
    checks++; if (ov_err !== 1'b1) begin errors++; $display("FAIL ov_set_priority got=%b exp=1", ov_err); end
    checks++; if (tx_count !== 5'd16) begin errors++; $display("FAIL ov_set_count got=%0d exp=16", tx_count); end
  endtask

  task automatic test_clear;
    fifo_clr = 1'b1; wr_en = 1'b1; wr_data = 8'h66;
    tick();
    fifo_clr = 1'b0; wr_en = 1'b0;
    checks++; if (tx_count !== 5'd0) begin errors++; $display("FAIL clr_full_count got=%0d exp=0", tx_count); end
    checks++; if (ov_err !== 1'b0) begin errors++; $display("FAIL clr_full_ov got=%b exp=0", ov_err); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL clr_full_data got=%h exp=00", tx_data); end
    for (int i = 0; i < 5; i++) push(8'hA0 + 8'(i));
    checks++; if (tx_count !== 5'd5) begin errors++; $display("FAIL clr_pre_count got=%0d exp=5", tx_count); end
    fifo_clr = 1'b1; wr_en = 1'b1; wr_data = 8'hDD; tx_done = 1'b1;
    tick();
    fifo_clr = 1'b0; wr_en = 1'b0; tx_done = 1'b0;
    checks++; if (tx_count !== 5'd0) begin errors++; $display("FAIL clr5_count got=%0d exp=0", tx_count); end
    checks++; if (tx_empty_status !== 1'b1) begin errors++; $display("FAIL clr5_empty got=%b exp=1", tx_empty_status); end
    checks++; if (ov_err !== 1'b0) begin errors++; $display("FAIL clr5_ov got=%b exp=0", ov_err); end
    push(8'h11);
    checks++; if (tx_data !== 8'h11) begin errors++; $display("FAIL clr_discard_head got=%h exp=11", tx_data); end
    checks++; if (tx_count !== 5'd1) begin errors++; $display("FAIL clr_discard_count got=%0d exp=1", tx_count); end
    fifo_clr = 1'b1; tick(); fifo_clr = 1'b0;
  endtask

  task automatic test_threshold_reset;
    thr_level = 4'd2;
    #1;
    checks++; if (tx_thr_int !== 1'b1) begin errors++; $display("FAIL thr_c0 got=%b exp=1", tx_thr_int); end
    push(8'hC0);
    checks++; if (tx_thr_int !== 1'b1) begin errors++; $display("FAIL thr_c1 got=%b exp=1", tx_thr_int); end
    push(8'hC1);
    checks++; if (tx_thr_int !== 1'b1) begin errors++; $display("FAIL thr_c2 got=%b exp=1", tx_thr_int); end
    push(8'hC2);
    checks++; if (tx_thr_int !== 1'b0) begin errors++; $display("FAIL thr_c3 got=%b exp=0", tx_thr_int); end
    push(8'hC3);
    checks++; if (tx_count !== 5'd4) begin errors++; $display("FAIL thr_c4_count got=%0d exp=4", tx_count); end
    rst_n = 1'b0;
    #2;
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL arst_data got=%h exp=00", tx_data); end
    checks++; if (tx_empty_status !== 1'b1) begin errors++; $display("FAIL arst_empty got=%b exp=1", tx_empty_status); end
    checks++; if (tx_full !== 1'b0) begin errors++; $display("FAIL arst_full got=%b exp=0", tx_full); end
    checks++; if (tx_count !== 5'd0) begin errors++; $display("FAIL arst_count got=%0d exp=0", tx_count); end
    checks++; if (tx_thr_int !== 1'b1) begin errors++; $display("FAIL arst_thr got=%b exp=1", tx_thr_int); end
    checks++; if (ov_err !== 1'b0) begin errors++; $display("FAIL arst_ov got=%b exp=0", ov_err); end
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_data = 8'h00; fifo_clr = 1'b0;
    tx_done = 1'b0; thr_level = 4'd0; ov_clr = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_wrap();
    test_simultaneous();
    test_clear();
    test_threshold_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
